// File: rtl/rv_mem_arbiter.sv
// Three-way arbiter (loader > data > fetch, with a fetch-starvation limit) in front of
// a single-ported word SRAM; formats byte/halfword/word accesses and flags bad addresses.
module rv_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STREAK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] STREAK_LIMIT = 4'(STREAK_MAX);

    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } func3_e;

    logic [3:0]  streak;
    logic        fetch_turn;
    logic        ld_ok;
    logic        d_ok;
    logic        d_align_ok;
    logic        i_ok;
    logic [2:0]  pend_func3;
    logic [1:0]  pend_off;
    logic [31:0] shifted;

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:ADDR_W+2] == '0;
    endfunction

    assign fetch_turn = i_req && (streak == STREAK_LIMIT);

    // NOTE: every signal assigned in an always_comb gets a default at the top of the
    // block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ld_gnt = 1'b0;
        d_gnt  = 1'b0;
        i_gnt  = 1'b0;
        if (!reset) begin
            if (ld_req)
                ld_gnt = 1'b1;
            else if (d_req && !fetch_turn)
                d_gnt = 1'b1;
            else if (i_req)
                i_gnt = 1'b1;
        end
    end

    always_comb begin
        d_align_ok = 1'b0;
        case (d_func3)
            F3_B, F3_BU: d_align_ok = 1'b1;
            F3_H, F3_HU: d_align_ok = ~d_addr[0];
            F3_W:        d_align_ok = (d_addr[1:0] == 2'b00);
            default:     d_align_ok = 1'b0;
        endcase
    end

    assign d_ok  = d_align_ok && in_range(d_addr);
    assign i_ok  = (i_addr[1:0] == 2'b00) && in_range(i_addr);
    assign ld_ok = (ld_addr[1:0] == 2'b00) && in_range(ld_addr);

    // A bad access is still granted but never reaches the SRAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr = ld_addr[ADDR_W+1:2];
            if (ld_ok) begin
                mem_en    = 1'b1;
                mem_we    = 4'b1111;
                mem_wdata = ld_wdata;
            end
        end else if (d_gnt) begin
            mem_addr = d_addr[ADDR_W+1:2];
            if (d_ok) begin
                mem_en = 1'b1;
                if (d_we) begin
                    case (d_func3[1:0])
                        2'd0: begin
                            mem_we    = 4'b0001 << d_addr[1:0];
                            mem_wdata = {4{d_wdata[7:0]}};
                        end
                        2'd1: begin
                            mem_we    = d_addr[1] ? 4'b1100 : 4'b0011;
                            mem_wdata = {2{d_wdata[15:0]}};
                        end
                        default: begin
                            mem_we    = 4'b1111;
                            mem_wdata = d_wdata;
                        end
                    endcase
                end
            end
        end else if (i_gnt) begin
            mem_addr = i_addr[ADDR_W+1:2];
            mem_en   = i_ok;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak     <= 4'd0;
            d_rvalid   <= 1'b0;
            d_err      <= 1'b0;
            i_rvalid   <= 1'b0;
            i_err      <= 1'b0;
            pend_func3 <= 3'd0;
            pend_off   <= 2'd0;
        end else begin
            if (!i_req || i_gnt)
                streak <= 4'd0;
            else if (d_gnt)
                streak <= streak + 4'd1;

            d_rvalid <= d_gnt && !d_we;
            d_err    <= d_gnt && !d_ok;
            i_rvalid <= i_gnt;
            i_err    <= i_gnt && !i_ok;

            if (d_gnt) begin
                pend_func3 <= d_func3;
                pend_off   <= d_addr[1:0];
            end
        end
    end

    assign shifted = mem_rdata >> {pend_off, 3'b000};

    always_comb begin
        d_rdata = '0;
        if (d_rvalid && !d_err) begin
            case (pend_func3)
                F3_B:    d_rdata = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:    d_rdata = {{16{shifted[15]}}, shifted[15:0]};
                F3_BU:   d_rdata = {24'd0, shifted[7:0]};
                F3_HU:   d_rdata = {16'd0, shifted[15:0]};
                default: d_rdata = shifted;
            endcase
        end
    end

    assign i_rdata = (i_rvalid && !i_err) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: a byte-array reference memory predicts grants,
// SRAM port activity and load/fetch responses; a monitor compares responses as they appear.
module tb_rv_mem_arbiter;
    localparam int ADDR_W     = 12;
    localparam int STREAK_MAX = 4;
    localparam int MEM_BYTES  = 4 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              ld_req, d_req, d_we, i_req;
    logic [31:0]       ld_addr, ld_wdata, d_addr, d_wdata, i_addr;
    logic [2:0]        d_func3;
    logic              ld_gnt, d_gnt, d_rvalid, d_err, i_gnt, i_rvalid, i_err;
    logic [31:0]       d_rdata, i_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    rv_mem_arbiter #(.ADDR_W(ADDR_W), .STREAK_MAX(STREAK_MAX)) dut (
        .clock(clock), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        v;
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
    } req_t;

    typedef struct {
        int        cyc;
        bit        rv;
        bit        err;
        bit [31:0] data;
    } rsp_t;

    rsp_t      dq[$];
    rsp_t      iq[$];
    bit [7:0]  ref_mem [MEM_BYTES];
    bit [31:0] sram [1 << ADDR_W];
    int        cyc = 0;
    int        n_checks = 0;
    int        n_pass = 0;
    int        m_streak = 0;
    req_t      ld_p, d_p, i_p;
    bit [2:0]  last_gnt;
    bit [3:0]  last_we;
    bit        last_en;
    bit [31:0] last_d_rdata, last_i_rdata;
    bit        last_d_rv, last_d_err, last_i_err;

    // SRAM macro: one-cycle read latency, byte-lane writes, garbage on non-read cycles.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_en && mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
        else                             mem_rdata <= $urandom;
        if (mem_en)
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int size_of(input bit [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit word_bad(input bit [31:0] a);
        return (a >= MEM_BYTES) || (a % 4 != 0);
    endfunction

    function automatic bit data_bad(input req_t r);
        int sz = size_of(r.f3);
        return (sz == 0) || (r.addr >= MEM_BYTES) || (r.addr % sz != 0);
    endfunction

    function automatic bit [31:0] read_ref(input bit [31:0] a, input int sz, input bit sgn);
        bit [31:0] v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[a + k];
        if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic write_ref(input bit [31:0] a, input int sz, input bit [31:0] d);
        for (int k = 0; k < sz; k++) ref_mem[a + k] = d[8*k +: 8];
    endtask

    function automatic rsp_t mk_rsp(input int c, input bit rv, input bit err, input bit [31:0] d);
        rsp_t r;
        r.cyc = c; r.rv = rv; r.err = err; r.data = d;
        return r;
    endfunction

    function automatic req_t mk_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                    input bit [31:0] wd);
        req_t r;
        r.v = 1'b1; r.we = we; r.f3 = f3; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    function automatic req_t rand_data();
        bit [2:0] legal [5]   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bit [2:0] illegal [3] = '{3'd3, 3'd6, 3'd7};
        req_t r;
        int sz;
        r.v  = 1'b1;
        r.we = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 19) == 0) r.f3 = illegal[$urandom_range(0, 2)];
        else                            r.f3 = legal[$urandom_range(0, 4)];
        if (r.we && (r.f3 == 3'd4 || r.f3 == 3'd5)) r.f3 = r.f3 - 3'd4;
        sz = size_of(r.f3);
        r.addr = 32'($urandom_range(0, 63));
        if (sz != 0 && $urandom_range(0, 9) != 0) r.addr = r.addr & ~32'(sz - 1);
        case ($urandom_range(0, 29))
            0:       r.addr = 32'h4000 | 32'($urandom_range(0, 63));
            1:       r.addr = 32'hFFFF_FFF0;
            default: ;
        endcase
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic req_t rand_word(input bit we);
        req_t r = mk_req(we, 3'd2, 32'($urandom_range(0, 15)) * 4, $urandom);
        if ($urandom_range(0, 9) == 0) r.addr = r.addr + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 24) == 0) r.addr = 32'h4000 + r.addr;
        return r;
    endfunction

    // One bus cycle: drive pending requests, predict and check the cycle, advance.
    task automatic step();
        bit        exp_ld, exp_d, exp_i, en, bad;
        bit [3:0]  we;
        bit [31:0] wd, a;
        int        sz;
        ld_req = ld_p.v; ld_addr = ld_p.addr; ld_wdata = ld_p.wdata;
        d_req = d_p.v; d_we = d_p.we; d_func3 = d_p.f3; d_addr = d_p.addr; d_wdata = d_p.wdata;
        i_req = i_p.v; i_addr = i_p.addr;
        @(negedge clock);
        exp_ld = ld_p.v;
        exp_d  = !ld_p.v && d_p.v && !(i_p.v && m_streak == STREAK_MAX);
        exp_i  = !ld_p.v && !exp_d && i_p.v;
        check("ld_gnt", ld_gnt, exp_ld);
        check("d_gnt", d_gnt, exp_d);
        check("i_gnt", i_gnt, exp_i);
        last_gnt = {ld_gnt, d_gnt, i_gnt};
        last_we  = mem_we;
        last_en  = mem_en;
        en = 0; we = '0; wd = '0; a = '0;
        if (exp_ld) begin
            a = ld_p.addr;
            if (!word_bad(a)) begin
                en = 1; we = 4'b1111; wd = ld_p.wdata;
                write_ref(a, 4, wd);
            end
        end else if (exp_d) begin
            a = d_p.addr; sz = size_of(d_p.f3); bad = data_bad(d_p);
            en = !bad;
            if (d_p.we) begin
                if (bad) dq.push_back(mk_rsp(cyc + 1, 1'b0, 1'b1, 32'd0));
                else begin
                    we = 4'(((1 << sz) - 1) << (a % 4));
                    for (int k = 0; k < 4; k++) wd[8*k +: 8] = d_p.wdata[8*(k % sz) +: 8];
                    write_ref(a, sz, d_p.wdata);
                end
            end else if (bad) dq.push_back(mk_rsp(cyc + 1, 1'b1, 1'b1, 32'd0));
            else dq.push_back(mk_rsp(cyc + 1, 1'b1, 1'b0, read_ref(a, sz, d_p.f3 < 3'd4)));
        end else if (exp_i) begin
            a = i_p.addr; bad = word_bad(a);
            en = !bad;
            iq.push_back(mk_rsp(cyc + 1, 1'b1, bad, bad ? 32'd0 : read_ref(a, 4, 1'b0)));
        end
        check("mem_en", mem_en, en);
        check("mem_we", mem_we, we);
        check("mem_wdata", mem_wdata, wd);
        if (en) check("mem_addr", mem_addr, a[ADDR_W+1:2]);
        if (exp_d && i_p.v)       m_streak++;
        else if (exp_i || !i_p.v) m_streak = 0;
        if (exp_ld) ld_p.v = 0;
        if (exp_d)  d_p.v = 0;
        if (exp_i)  i_p.v = 0;
        @(posedge clock); #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnts"}, {ld_gnt, d_gnt, i_gnt}, 3'b000);
        check({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        check({tag, "_d_err"}, d_err, 1'b0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_i_rvalid"}, i_rvalid, 1'b0);
        check({tag, "_i_err"}, i_err, 1'b0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_mem_en"}, mem_en, 1'b0);
        check({tag, "_mem_we"}, mem_we, 4'b0000);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clock) begin
        rsp_t e;
        if (!reset) begin
            if (d_rvalid || d_err) begin
                if (dq.size() == 0) check("d_unexpected_rsp", {d_rvalid, d_err}, 2'b00);
                else begin
                    e = dq.pop_front();
                    check("d_rsp_cycle", cyc, e.cyc);
                    check("d_rvalid", d_rvalid, e.rv);
                    check("d_err", d_err, e.err);
                    check("d_rdata", d_rdata, e.data);
                    last_d_rv = d_rvalid; last_d_err = d_err; last_d_rdata = d_rdata;
                end
            end else begin
                check("d_rdata_idle", d_rdata, 32'd0);
                if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                    void'(dq.pop_front());
                    check("d_rsp_missing", {d_rvalid, d_err}, 2'b11);
                end
            end
            if (i_rvalid) begin
                if (iq.size() == 0) check("i_unexpected_rsp", i_rvalid, 1'b0);
                else begin
                    e = iq.pop_front();
                    check("i_rsp_cycle", cyc, e.cyc);
                    check("i_err", i_err, e.err);
                    check("i_rdata", i_rdata, e.data);
                    last_i_err = i_err; last_i_rdata = i_rdata;
                end
            end else begin
                check("i_rdata_idle", i_rdata, 32'd0);
                check("i_err_alone", i_err, 1'b0);
                if (iq.size() != 0 && iq[0].cyc <= cyc) begin
                    void'(iq.pop_front());
                    check("i_rsp_missing", i_rvalid, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int run, max_run, n_fetch;
        bit [2:0] g1, g2, g3;

        // Reset with every requester asserted: nothing may leak out.
        reset = 1'b1;
        ld_req = 1; ld_addr = 32'h10; ld_wdata = 32'h1;
        d_req = 1; d_we = 1; d_func3 = 3'd2; d_addr = 32'h10; d_wdata = 32'h2;
        i_req = 1; i_addr = 32'h10;
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        ld_p.v = 0; d_p.v = 0; i_p.v = 0; m_streak = 0;

        // Loader preload, then fetch of the same word.
        ld_p = mk_req(1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        step();
        check("preload_ld_gnt", last_gnt, 3'b100);
        i_p = mk_req(0, 3'd2, 32'h10, 0);
        step(); step();
        check("preload_i_rdata", last_i_rdata, 32'hDEAD_BEEF);
        check("preload_i_err", last_i_err, 1'b0);

        // Byte / halfword formatting.
        d_p = mk_req(1, 3'd0, 32'h13, 32'h0000_0080);
        step();
        check("sb_mem_we", last_we, 4'b1000);
        d_p = mk_req(0, 3'd0, 32'h13, 0);
        step(); step();
        check("lb_rdata", last_d_rdata, 32'hFFFF_FF80);
        d_p = mk_req(0, 3'd4, 32'h13, 0);
        step(); step();
        check("lbu_rdata", last_d_rdata, 32'h0000_0080);
        d_p = mk_req(1, 3'd1, 32'h22, 32'h0000_1234);
        step();
        check("sh_mem_we", last_we, 4'b1100);
        d_p = mk_req(0, 3'd2, 32'h20, 0);
        step(); step();
        check("lw_upper_half", last_d_rdata[31:16], 16'h1234);

        // Fairness under continuous data and fetch requests.
        drain(1);
        run = 0; max_run = 0; n_fetch = 0;
        for (int n = 0; n < 20; n++) begin
            if (!d_p.v) d_p = mk_req(0, 3'd2, 32'($urandom_range(0, 15)) * 4, 0);
            if (!i_p.v) i_p = mk_req(0, 3'd2, 32'($urandom_range(0, 15)) * 4, 0);
            step();
            if (last_gnt == 3'b010) begin
                run++;
                if (run > max_run) max_run = run;
            end else if (last_gnt == 3'b001) begin
                n_fetch++;
                run = 0;
            end
        end
        check("fair_max_d_run", max_run, STREAK_MAX);
        check("fair_fetch_count", n_fetch, 20 / (STREAK_MAX + 1));

        // Contention: loader wins and the streak is held (two data grants already in).
        for (int n = 0; n < 2; n++) begin
            if (!d_p.v) d_p = mk_req(0, 3'd2, 32'h20, 0);
            if (!i_p.v) i_p = mk_req(0, 3'd2, 32'h10, 0);
            step();
        end
        ld_p = mk_req(1, 3'd2, 32'h40, 32'hA5A5_5A5A);
        if (!d_p.v) d_p = mk_req(0, 3'd2, 32'h20, 0);
        step();
        check("contention_gnt", last_gnt, 3'b100);
        step(); g1 = last_gnt;
        if (!d_p.v) d_p = mk_req(0, 3'd2, 32'h24, 0);
        step(); g2 = last_gnt;
        if (!d_p.v) d_p = mk_req(0, 3'd2, 32'h28, 0);
        step(); g3 = last_gnt;
        check("contention_streak_held", {g1, g2, g3}, {3'b010, 3'b010, 3'b001});
        drain(4);

        // Error cases.
        d_p = mk_req(0, 3'd2, 32'h21, 0);
        step();
        check("lw_mis_mem_en", last_en, 1'b0);
        step();
        check("lw_mis_rvalid", last_d_rv, 1'b1);
        check("lw_mis_err", last_d_err, 1'b1);
        check("lw_mis_rdata", last_d_rdata, 32'd0);
        i_p = mk_req(0, 3'd2, 32'h4000, 0);
        step(); step();
        check("fetch_oor_err", last_i_err, 1'b1);
        d_p = mk_req(1, 3'd2, 32'h4000, 32'h1234_5678);
        step();
        check("sw_oor_mem_we", last_we, 4'b0000);
        step();
        check("sw_oor_err", last_d_err, 1'b1);
        check("sw_oor_no_rvalid", last_d_rv, 1'b0);

        // Reset in the cycle after a load grant.
        d_p = mk_req(0, 3'd2, 32'h20, 0);
        step();
        reset = 1'b1;
        dq.delete(); iq.delete(); m_streak = 0;
        ld_req = 1; d_req = 1; i_req = 1;
        @(negedge clock);
        check_all_zero("mid_reset");
        ld_req = 0; d_req = 0; i_req = 0;
        ld_p.v = 0; d_p.v = 0; i_p.v = 0;
        reset = 1'b0;
        @(posedge clock); #1;
        drain(3);
        d_p = mk_req(0, 3'd2, 32'h10, 0);
        step(); step();
        check("post_reset_lw", last_d_rdata, 32'h80AD_BEEF);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if (!ld_p.v && $urandom_range(0, 9) == 0) ld_p = rand_word(1'b1);
            if (!d_p.v && $urandom_range(0, 2) != 0)  d_p = rand_data();
            if (!i_p.v && $urandom_range(0, 1) == 0)  i_p = rand_word(1'b0);
            step();
        end
        drain(8);
        check("d_queue_empty", dq.size(), 0);
        check("i_queue_empty", iq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Shares one single-ported, word-wide synchronous SRAM among three requesters: the RV32I instruction-fetch port, the RV32I data port, and a program loader. It arbitrates the requesters with a grant handshake and converts func3-coded byte, halfword and word accesses into byte-lane writes and sign- or zero-extended reads. It flags misaligned and out-of-range accesses. It sits between the core's pm*/dm* buses and the SRAM macro.

## Interface
- ADDR_W, 12: SRAM word-address width; valid byte range is 0 .. (4<<ADDR_W)-1.
- STREAK_MAX, 4: maximum consecutive data grants while a fetch waits (1..15).

- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- ld_req  in  1  loader word-write request.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_gnt  out  1  loader accepted this cycle.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_func3  in  3  access size: 0 = b, 1 = h, 2 = w, 4 = bu, 5 = hu.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  formatted load data.
- d_err  out  1  error, qualifies d_rvalid, or pulses alone for a bad store.
- i_req  in  1  fetch request (always a word).
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted.
- i_rvalid  out  1  instruction valid.
- i_rdata  out  32  instruction word.
- i_err  out  1  fetch error, qualifies i_rvalid.
- mem_en  out  1  SRAM cycle enable.
- mem_we  out  4  byte-lane write enables.
- mem_addr  out  ADDR_W  SRAM word address, equal to addr[ADDR_W+1:2].
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  SRAM read data, valid one cycle after an enabled read.

## Operation
- **Priority.**
  - Loader beats data and fetch.
  - Data beats fetch, except when the streak counter equals STREAK_MAX and i_req=1; then fetch wins.
- **Grants.**
  - At most one gnt is asserted per cycle.
  - gnt is combinational from the same-cycle req inputs.
  - A requester holds req and its operands stable until it sees gnt.
- **Streak counter (4-bit).**
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant, or on any cycle with i_req=0.
  - Holds on loader grants.
- **Address checks.**
  - Out-of-range: address ≥ 4<<ADDR_W.
  - Misaligned: h/hu with addr[0]=1, or w/fetch/loader with addr[1:0]≠0.
- **Bad access.** When a granted access fails a check:
  - It is still granted.
  - mem_en=0 and mem_we=0.
  - The error is reported the next cycle:
    - Bad load or fetch: rvalid=1, err=1, rdata=0.
    - Bad store: d_err pulses with d_rvalid=0.
  - Bad loader writes are silently dropped.
- **Stores.**
  - sb: mem_we = 1<<addr[1:0]; byte replicated ×4.
  - sh: mem_we = 4'b0011 or 4'b1100 per addr[1]; halfword replicated ×2.
  - sw and loader: mem_we = 4'b1111.
  - Stores produce no rvalid.
- **Loads.**
  - A one-entry pending register records port, func3 and addr[1:0].
  - Next cycle, mem_rdata is shifted right by 8×addr[1:0].
  - b/h are sign-extended; bu/hu are zero-extended; w passes through.
  - Fetch data is passed through unchanged.
- **Unsupported func3** (3, 6, 7) is treated as an error, like misalignment.

## Timing
- **Reset values.**
  - All outputs are 0.
  - Streak counter is 0; pending register is empty.
- **Latency.**
  - Grant in cycle N.
  - SRAM is driven in cycle N.
  - rvalid/rdata/err are asserted for exactly one cycle, N+1.
  - Back-to-back grants are allowed every cycle: full throughput, one access per cycle.
- **Outputs when idle.**
  - rdata is 0 whenever rvalid=0.
  - mem_wdata is 0 when mem_we=0.
- **Simultaneous requests.**
  - Loader present: loader wins.
  - Data and fetch only: data wins unless the streak condition holds.
- **Reset mid-operation.**
  - A pending read is discarded; no rvalid follows reset deassertion.
  - The streak counter is cleared.
- **Fairness bound.** With continuous d_req and i_req and no loader, fetch is granted at least once every STREAK_MAX+1 cycles.

## Test plan
- **Loader preload.** Loader writes 0xDEADBEEF to 0x10, then fetch 0x10 → ld_gnt, then i_gnt; i_rvalid next cycle with i_rdata=0xDEADBEEF, i_err=0.
- **Byte/halfword formatting.**
  - sb 0x80 to 0x13 → mem_we=4'b1000.
  - Then lb 0x13 → d_rdata=0xFFFFFF80.
  - lbu 0x13 → 0x00000080.
  - sh 0x1234 to 0x22, then lw 0x20 → upper half = 0x1234.
- **Fairness.** d_req and i_req held high for 20 cycles, STREAK_MAX=4 → grant pattern DDDDI repeated; never more than 4 consecutive d_gnt.
- **Contention.** ld_req, d_req and i_req all high in one cycle → only ld_gnt=1; streak counter unchanged.
- **Errors.**
  - lw 0x21 → d_gnt, mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
  - Fetch of 0x4000 with ADDR_W=12 → i_err=1.
  - sw to 0x4000 → d_err pulse, mem_we=0.
- **Reset mid-read.** Assert reset in the cycle after a lw grant → d_rvalid stays 0, all outputs 0, next access behaves normally.
